// File: rtl/fc_acc_buf.sv
// rtl/fc_acc_buf.sv - FC accumulation buffer with scaled sequential readout
//
// Purpose:
//   Per-lane read-modify-write accumulation of BATCH MAC results into on-chip
//   memory (two-stage R/W pipeline with distance-1 forwarding), plus a readout
//   FSM that streams arithmetically shifted, width-reduced words.
//   Optional feature macro: FC_ACC_SAT_EN. When defined, readout reduction
//   saturates to the signed DW range; otherwise it keeps the low DW bits.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   acc_addr/en/new     accumulate address, per-lane enable, overwrite select
//   acc_data            BATCH x DW signed MAC results, lane i at [i*DW +: DW]
//   rd_start            one-cycle pulse starting a readout
//   rd_base/rd_len      first readout address and entry count
//   conf_shift          arithmetic right shift applied on readout
//   out_vld/addr/data   readout stream
//   rd_done             one-cycle pulse when readout completes
//   busy                readout FSM not idle
//   err                 sticky: accumulate dropped while busy

module fc_acc_buf #(
  parameter int ADDR_W = 8,
  parameter int BATCH  = 32,
  parameter int DW     = 16,
  parameter int AW     = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     acc_addr,
  input  logic [BATCH-1:0]      acc_en,
  input  logic                  acc_new,
  input  logic [BATCH*DW-1:0]   acc_data,
  input  logic                  rd_start,
  input  logic [ADDR_W-1:0]     rd_base,
  input  logic [ADDR_W:0]       rd_len,
  input  logic [4:0]            conf_shift,
  output logic                  out_vld,
  output logic [ADDR_W-1:0]     out_addr,
  output logic [BATCH*DW-1:0]   out_data,
  output logic                  rd_done,
  output logic                  busy,
  output logic                  err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_ONE = 1;
  localparam logic [ADDR_W:0]   CNT_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [4:0]          shift_q, shift_d;
  logic                rd_issue;

  // W stage registers
  logic [BATCH-1:0]    w_en_q, w_en_d;
  logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
  logic                w_new_q, w_new_d;
  logic [BATCH*DW-1:0] w_data_q, w_data_d;

  // The write committed last cycle, kept for forwarding
  logic [BATCH-1:0]    wb_en_q, wb_en_d;
  logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic [AW-1:0]       wb_sum_q [BATCH];
  logic [AW-1:0]       wb_sum_d [BATCH];
  logic [AW-1:0]       acc_old  [BATCH];

  logic [AW-1:0]       mem [BATCH][DEPTH];
  logic [AW-1:0]       mem_rdata_q [BATCH];
  logic [AW-1:0]       mem_rdata_d [BATCH];
  logic [ADDR_W-1:0]   mem_raddr;
  logic                mem_we;

  // Readout pipeline
  logic                rd_vld1_q, rd_vld1_d;
  logic [ADDR_W-1:0]   rd_addr1_q, rd_addr1_d;
  logic                out_vld_q, out_vld_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [BATCH*DW-1:0] out_data_q, out_data_d;
  logic                rd_done_q, rd_done_d;
  logic                err_q, err_d;

  function automatic logic [AW-1:0] sext(input logic [DW-1:0] v);
    return {{(AW-DW){v[DW-1]}}, v};
  endfunction

`ifdef FC_ACC_SAT_EN
  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  function automatic logic [DW-1:0] reduce(input logic [AW-1:0] v, input logic [4:0] sh);
    logic signed [AW-1:0] s;
    s = $signed(v) >>> sh;
    if (s > SAT_MAX) return {1'b0, {(DW-1){1'b1}}};
    if (s < SAT_MIN) return {1'b1, {(DW-1){1'b0}}};
    return DW'(s);
  endfunction
`else
  function automatic logic [DW-1:0] reduce(input logic [AW-1:0] v, input logic [4:0] sh);
    logic signed [AW-1:0] s;
    s = $signed(v) >>> sh;
    return DW'(s);
  endfunction
`endif

  assign busy = (state_q != S_IDLE);

  // Readout FSM
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    rd_issue  = 1'b0;
    rd_done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rd_start) begin
          ptr_d   = rd_base;
          cnt_d   = rd_len;
          shift_d = conf_shift;
          state_d = (rd_len == '0) ? S_DRAIN : S_READ;
        end
      end
      S_READ: begin
        rd_issue = 1'b1;
        ptr_d    = ptr_q + PTR_ONE;
        cnt_d    = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Once no read is left in the memory stage, the final word is being
        // registered this cycle; rd_done appears alongside the cycle after it.
        if (rd_done_q) state_d = S_IDLE;
        else if (!rd_vld1_q) rd_done_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Accumulate pipeline and readout datapath
  always_comb begin
    // Accumulates arriving while a readout owns the read port are dropped
    w_en_d   = busy ? '0 : acc_en;
    w_addr_d = acc_addr;
    w_new_d  = acc_new;
    w_data_d = acc_data;
    err_d    = err_q | (busy && (acc_en != '0));

    mem_we    = (w_en_q != '0) && !rst;
    wb_en_d   = mem_we ? w_en_q : '0;
    wb_addr_d = w_addr_q;

    // Memory is read-first: a write to the same address in the previous
    // cycle is not yet visible in mem_rdata_q, so take it from wb_sum_q.
    for (int l = 0; l < BATCH; l++) begin
      acc_old[l]  = (wb_en_q[l] && (wb_addr_q == w_addr_q)) ? wb_sum_q[l] : mem_rdata_q[l];
      wb_sum_d[l] = w_new_q ? sext(w_data_q[l*DW +: DW])
                            : acc_old[l] + sext(w_data_q[l*DW +: DW]);
    end

    mem_raddr = rd_issue ? ptr_q : acc_addr;
    for (int l = 0; l < BATCH; l++) begin
      mem_rdata_d[l] = mem[l][mem_raddr];
    end

    rd_vld1_d  = rd_issue;
    rd_addr1_d = ptr_q;
    out_vld_d  = rd_vld1_q;
    out_addr_d = rd_vld1_q ? rd_addr1_q : out_addr_q;
    out_data_d = out_data_q;
    if (rd_vld1_q) begin
      for (int l = 0; l < BATCH; l++) begin
        out_data_d[l*DW +: DW] = reduce(mem_rdata_q[l], shift_q);
      end
    end
  end

  // Memory array, read register and forwarding data: no reset
  always_ff @(posedge clk) begin
    for (int l = 0; l < BATCH; l++) begin
      mem_rdata_q[l] <= mem_rdata_d[l];
      wb_sum_q[l]    <= wb_sum_d[l];
      if (mem_we && w_en_q[l]) mem[l][w_addr_q] <= wb_sum_d[l];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      shift_q    <= '0;
      w_en_q     <= '0;
      w_addr_q   <= '0;
      w_new_q    <= 1'b0;
      w_data_q   <= '0;
      wb_en_q    <= '0;
      wb_addr_q  <= '0;
      rd_vld1_q  <= 1'b0;
      rd_addr1_q <= '0;
      out_vld_q  <= 1'b0;
      out_addr_q <= '0;
      out_data_q <= '0;
      rd_done_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      w_en_q     <= w_en_d;
      w_addr_q   <= w_addr_d;
      w_new_q    <= w_new_d;
      w_data_q   <= w_data_d;
      wb_en_q    <= wb_en_d;
      wb_addr_q  <= wb_addr_d;
      rd_vld1_q  <= rd_vld1_d;
      rd_addr1_q <= rd_addr1_d;
      out_vld_q  <= out_vld_d;
      out_addr_q <= out_addr_d;
      out_data_q <= out_data_d;
      rd_done_q  <= rd_done_d;
      err_q      <= err_d;
    end
  end

  assign out_vld  = out_vld_q;
  assign out_addr = out_addr_q;
  assign out_data = out_data_q;
  assign rd_done  = rd_done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_fc_acc_buf.sv
// tb/tb_fc_acc_buf.sv - self-checking bench for fc_acc_buf
module tb_fc_acc_buf;
  localparam int ADDR_W = 8;
  localparam int BATCH  = 32;
  localparam int DW     = 16;
  localparam int AW     = 32;
  localparam int DEPTH  = 256;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [ADDR_W-1:0]     acc_addr;
  logic [BATCH-1:0]      acc_en;
  logic                  acc_new;
  logic [BATCH*DW-1:0]   acc_data;
  logic                  rd_start;
  logic [ADDR_W-1:0]     rd_base;
  logic [ADDR_W:0]       rd_len;
  logic [4:0]            conf_shift;
  logic                  out_vld;
  logic [ADDR_W-1:0]     out_addr;
  logic [BATCH*DW-1:0]   out_data;
  logic                  rd_done;
  logic                  busy;
  logic                  err;

  always #5 clk = ~clk;

  fc_acc_buf #(.ADDR_W(ADDR_W), .BATCH(BATCH), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .acc_addr(acc_addr), .acc_en(acc_en), .acc_new(acc_new),
    .acc_data(acc_data), .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
    .conf_shift(conf_shift), .out_vld(out_vld), .out_addr(out_addr), .out_data(out_data),
    .rd_done(rd_done), .busy(busy), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_int(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_vec(input string name, input logic [BATCH*DW-1:0] act,
                           input logic [BATCH*DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int mem_m [BATCH][DEPTH];
  typedef struct {int a; logic [BATCH*DW-1:0] d;} word_t;
  typedef struct {int c; int a; logic [BATCH*DW-1:0] d;} cap_t;
  word_t exp_q[$];
  cap_t  cap_q[$];
  bit act_m = 0;
  int rs_s = 0, rs_len = 0, rs_done = 0;
  bit err_m = 0;
  bit armed = 0;
  bit pend_v = 0;
  int pend_a;
  logic [BATCH-1:0] pend_en;
  bit pend_new;
  logic [BATCH*DW-1:0] pend_d;
  int last_done_cyc = -1;

  function automatic logic [DW-1:0] reduce_m(input int v, input int sh);
    int s;
    s = v >>> sh;
`ifdef FC_ACC_SAT_EN
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`endif
    return s[15:0];
  endfunction

  always @(negedge clk) begin
    bit e_busy, e_vld, e_done;
    word_t w;
    logic [BATCH*DW-1:0] wd;
    int a, d;
    e_busy = act_m && cyc >= rs_s + 1 && cyc <= rs_done;
    e_vld  = act_m && rs_len > 0 && cyc >= rs_s + 3 && cyc <= rs_s + 2 + rs_len;
    e_done = act_m && cyc == rs_done;
    if (armed) begin
      check_int("busy", 32'(busy), 32'(e_busy));
      check_int("out_vld", 32'(out_vld), 32'(e_vld));
      check_int("rd_done", 32'(rd_done), 32'(e_done));
      check_int("err", 32'(err), 32'(err_m));
      if (e_vld && exp_q.size() > 0) begin
        w = exp_q.pop_front();
        check_int("out_addr", 32'(out_addr), w.a);
        check_vec("out_data", out_data, w.d);
      end
    end
    if (out_vld === 1'b1) cap_q.push_back('{cyc, int'(out_addr), out_data});
    if (rd_done === 1'b1) last_done_cyc = cyc;

    if (rst) begin
      act_m = 0; exp_q.delete(); err_m = 0; pend_v = 0; armed = 1;
    end else begin
      if (pend_v) begin
        for (int l = 0; l < BATCH; l++) begin
          if (pend_en[l]) begin
            d = $signed(pend_d[l*DW +: DW]);
            mem_m[l][pend_a] = pend_new ? d : mem_m[l][pend_a] + d;
          end
        end
        pend_v = 0;
      end
      if (rd_start && !e_busy) begin
        act_m = 1; rs_s = cyc; rs_len = int'(rd_len);
        rs_done = (rs_len == 0) ? cyc + 2 : cyc + 3 + rs_len;
        exp_q.delete();
        for (int i = 0; i < rs_len; i++) begin
          a = (int'(rd_base) + i) % DEPTH;
          for (int l = 0; l < BATCH; l++) wd[l*DW +: DW] = reduce_m(mem_m[l][a], int'(conf_shift));
          exp_q.push_back('{a, wd});
        end
      end
      if (acc_en != '0) begin
        if (e_busy) err_m = 1;
        else begin
          pend_v = 1; pend_a = int'(acc_addr); pend_en = acc_en;
          pend_new = acc_new; pend_d = acc_data;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [BATCH*DW-1:0] fill(input logic [DW-1:0] x);
    return {BATCH{x}};
  endfunction

  function automatic logic [BATCH*DW-1:0] rand_data();
    logic [BATCH*DW-1:0] v;
    for (int l = 0; l < BATCH; l++) v[l*DW +: DW] = 16'($urandom);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic acc_op(input int a, input logic [BATCH-1:0] en, input logic nw,
                        input logic [BATCH*DW-1:0] dat);
    acc_addr = 8'(a); acc_en = en; acc_new = nw; acc_data = dat;
    tick();
    acc_en = '0;
  endtask

  task automatic readout(input int b, input int l, input int sh, output int s);
    cap_q.delete();
    rd_base = 8'(b); rd_len = 9'(l); conf_shift = 5'(sh); rd_start = 1'b1; s = cyc;
    tick();
    rd_start = 1'b0;
    repeat (l + 6) tick();
  endtask

  initial begin
    int s;
    int wrap_exp [4];
    logic [BATCH*DW-1:0] ev;
    wrap_exp = '{254, 255, 0, 1};
    rst = 1'b1; acc_addr = '0; acc_en = '0; acc_new = 1'b0; acc_data = '0;
    rd_start = 1'b0; rd_base = '0; rd_len = '0; conf_shift = '0;
    repeat (3) tick();
    check_int("rst_out_vld", 32'(out_vld), 0);
    check_int("rst_out_addr", 32'(out_addr), 0);
    check_vec("rst_out_data", out_data, '0);
    check_int("rst_rd_done", 32'(rd_done), 0);
    check_int("rst_busy", 32'(busy), 0);
    check_int("rst_err", 32'(err), 0);
    rst = 1'b0;

    // give every entry a known value
    for (int a = 0; a < DEPTH; a++) acc_op(a, '1, 1'b1, rand_data());
    tick();

    // new then accumulate, back-to-back forwarding
    acc_op(5, '1, 1'b1, fill(16'd3));
    repeat (3) acc_op(5, '1, 1'b0, fill(16'd2));
    readout(5, 1, 0, s);
    check_int("fwd_count", cap_q.size(), 1);
    if (cap_q.size() > 0) check_vec("fwd_value", cap_q[0].d, fill(16'd9));

    // lane mask
    acc_op(10, '1, 1'b1, fill(16'd4));
    acc_op(10, 32'h1, 1'b1, fill(16'd7));
    readout(10, 1, 0, s);
    ev = fill(16'd4); ev[15:0] = 16'd7;
    if (cap_q.size() > 0) check_vec("lane_mask", cap_q[0].d, ev);

    // interleaved A/B
    acc_op(20, '1, 1'b1, fill(16'd0));
    acc_op(21, '1, 1'b1, fill(16'd0));
    for (int k = 0; k < 4; k++) acc_op(20 + (k % 2), '1, 1'b0, fill(16'd1));
    readout(20, 2, 0, s);
    check_int("ileave_count", cap_q.size(), 2);
    for (int i = 0; i < 2 && i < cap_q.size(); i++) check_vec("ileave_val", cap_q[i].d, fill(16'd2));

    // wrap, timing, ignored second start
    cap_q.delete();
    rd_base = 8'd254; rd_len = 9'd4; conf_shift = 5'd0; rd_start = 1'b1; s = cyc;
    tick();
    rd_start = 1'b0; tick();
    rd_base = 8'd100; rd_len = 9'd3; rd_start = 1'b1; tick();
    rd_start = 1'b0; repeat (10) tick();
    check_int("wrap_count", cap_q.size(), 4);
    for (int i = 0; i < 4 && i < cap_q.size(); i++) begin
      check_int("wrap_addr", cap_q[i].a, wrap_exp[i]);
      check_int("wrap_cycle", cap_q[i].c, s + 3 + i);
    end
    check_int("wrap_done", last_done_cyc, s + 7);

    // zero length
    readout(3, 0, 0, s);
    check_int("len0_count", cap_q.size(), 0);
    check_int("len0_done", last_done_cyc, s + 2);

    // reduction: 0x0010_0000 >>> 4 and -70000
    acc_op(40, '1, 1'b1, fill(16'h7fff));
    repeat (31) acc_op(40, '1, 1'b0, fill(16'h7fff));
    acc_op(40, '1, 1'b0, fill(16'd32));
    readout(40, 1, 4, s);
`ifdef FC_ACC_SAT_EN
    if (cap_q.size() > 0) check_vec("sat_pos", cap_q[0].d, fill(16'h7fff));
`else
    if (cap_q.size() > 0) check_vec("trunc_pos", cap_q[0].d, fill(16'h0000));
`endif
    acc_op(41, '1, 1'b1, fill(16'h8000));
    acc_op(41, '1, 1'b0, fill(16'h8000));
    acc_op(41, '1, 1'b0, fill(16'hee90));
    readout(41, 1, 0, s);
`ifdef FC_ACC_SAT_EN
    if (cap_q.size() > 0) check_vec("sat_neg", cap_q[0].d, fill(16'h8000));
`else
    if (cap_q.size() > 0) check_vec("trunc_neg", cap_q[0].d, fill(16'hee90));
`endif

    // dropped accumulate sets err; reset mid-READ
    rd_base = 8'd50; rd_len = 9'd100; conf_shift = 5'd0; rd_start = 1'b1;
    tick();
    rd_start = 1'b0; tick();
    acc_op(50, '1, 1'b1, fill(16'h7777));
    check_int("err_set", 32'(err), 1);
    tick();
    check_int("err_sticky", 32'(err), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check_int("rst_mid_busy", 32'(busy), 0);
    check_int("rst_mid_vld", 32'(out_vld), 0);
    check_int("rst_mid_err", 32'(err), 0);
    tick();
    readout(50, 1, 0, s);

    // randomized traffic
    for (int it = 0; it < 700; it++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 55) begin
        acc_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(60, 63));
        acc_en   = ($urandom_range(0, 1) == 1) ? '1 : $urandom;
        acc_new  = ($urandom_range(0, 3) == 0);
        acc_data = rand_data();
      end else if (r < 67) begin
        rd_start = 1'b1; rd_base = 8'($urandom); rd_len = 9'($urandom_range(0, 12));
        conf_shift = 5'($urandom);
      end else if (r < 69) begin
        rst = 1'b1;
      end
      tick();
      acc_en = '0; rd_start = 1'b0; rst = 1'b0;
    end
    repeat (30) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fc_acc_buf.md
# fc_acc_buf

Accumulation buffer for the fully-connected path. Consumes the address, lane-enable and new-accumulation stream produced by the FC address generator plus BATCH MAC results per cycle, and performs per-lane read-modify-write accumulation into on-chip memory. On command, a sequential readout streams scaled, width-reduced results to the output writer.

## Interface
Parameters:
- ADDR_W, 8, accumulator address width; depth 2^ADDR_W per lane
- BATCH, 32, number of lanes
- DW, 16, MAC result and output data width, signed
- AW, 32, accumulator word width, signed

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous active-high reset
- acc_addr  in  ADDR_W  accumulate address
- acc_en  in  BATCH  per-lane accumulate enable
- acc_new  in  1  1: overwrite lane with incoming data; 0: add to stored value
- acc_data  in  BATCH*DW  MAC results, lane i at [i*DW +: DW]
- rd_start  in  1  one-cycle pulse starting readout
- rd_base  in  ADDR_W  first readout address
- rd_len  in  ADDR_W+1  number of entries to read
- conf_shift  in  5  arithmetic right shift applied on readout; sampled at rd_start
- out_vld  out  1  readout data valid
- out_addr  out  ADDR_W  address of current output word
- out_data  out  BATCH*DW  scaled results
- rd_done  out  1  one-cycle pulse, readout complete
- busy  out  1  readout FSM not IDLE
- err  out  1  sticky: accumulate request dropped during readout

## Operation
- Accumulate pipeline, two stages:
  - R (cycle t): acc_en/acc_addr/acc_new/acc_data registered; memory read of acc_addr issued on all lanes.
  - W (cycle t+1): per enabled lane: sum = acc_new ? sext(data) : old + sext(data), wrapping modulo 2^AW. Result written to acc_addr. Disabled lanes are not written.
- Hazard forwarding: the memory is read-first. If the op in W at t+1 has the same address as the op that wrote in cycle t, then for each lane written at t, old = that written sum instead of memory output. Lanes not written at t use memory output. Only distance-1 hazards exist.
- Readout FSM states:
  - IDLE: rd_start moves to READ, latching base, len and shift. If rd_len==0, go to DRAIN with no reads issued.
  - READ: issues one address per cycle, base..base+len-1, wrapping modulo 2^ADDR_W. After the last issue, go to DRAIN.
  - DRAIN: waits for the last output to be issued, pulses rd_done, then goes to IDLE.
- Readout data path: out_data lane = reduce(acc >>> shift) to DW bits; see Configuration.
- rd_start while busy is ignored.
- If acc_en!=0 while busy, the accumulate op is dropped (no memory write) and err is set. err clears only on rst.
- Accumulate ops already in W when rd_start arrives complete normally. Readout issues its first read the cycle after rd_start. Forwarding is not applied to readout.
- Memory contents are not reset.

## Timing
- Reset values: out_vld=0, out_addr=0, out_data=0, rd_done=0, busy=0, err=0; FSM in IDLE; pipeline valid bits cleared.
- Accumulate latency: write committed at t+1. A readout issued at t+2 or later observes it.
- Readout:
  - rd_start at cycle s → busy=1 at s+1.
  - First read issued at s+1; first out_vld at s+3; one word per cycle, no backpressure.
  - Last out_vld at s+2+len; rd_done at s+3+len; busy=0 at s+4+len.
  - rd_len==0: no out_vld; rd_done at s+2.
- rst asserted mid-readout or mid-accumulate: the in-flight op is abandoned, outputs return to reset values next cycle, and the memory write in that cycle is suppressed.

## Configuration
- FC_ACC_SAT_EN defined: reduction saturates the shifted value to [-2^(DW-1), 2^(DW-1)-1].
- FC_ACC_SAT_EN undefined: reduction truncates to the low DW bits (two's-complement wrap).

## Test plan
- New then accumulate: addr 5, all lanes, acc_new=1 data 3, then three cycles acc_new=0 data 2 back-to-back. Readout base 5 len 1 shift 0 → every lane 9 (exercises forwarding).
- Lane mask: acc_en=0x0000_0001, data 7, acc_new=1 on an address holding 4 in all lanes → lane0=7, other lanes=4.
- Interleaved hazard: addr A, B, A, B alternating, each data 1, acc_new=0 from 0. Readout → 2 at both A and B; no distance-1 forwarding misfire.
- Readout timing and wrap: base 254, len 4 at ADDR_W=8 → out_addr 254, 255, 0, 1 on consecutive cycles; rd_done one cycle after the last; second rd_start while busy ignored. rd_len=0 → rd_done at s+2, no out_vld.
- Saturation: value 0x0010_0000, shift 4 → 32767 with FC_ACC_SAT_EN; 0x0000 without it. Value -70000, shift 0 → -32768 with FC_ACC_SAT_EN.
- Error/reset: acc_en=all ones during READ → no write, err=1 until rst. rst mid-READ → busy=0 and out_vld=0 the next cycle.
